conv2_ctrl: RTL

//  Control for the 2nd conv layer, and the read side of the pooled feature map f3 (14x14)

---
 rtl/conv2_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/conv2_ctrl.sv
// Control for the second conv layer: scans 5x5 windows over the 14x14 pooled map f3
// and emits read addresses, accumulator clear, f4 write strobes and a done pulse.
module conv2_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       conv2_start,
  output logic [7:0] f3_raddr,
  output logic [4:0] w2_raddr,
  output logic       conv2_clr,
  output logic [6:0] f4_waddr,
  output logic       f4_wr_en,
  output logic       conv2_done
);

  localparam int K       = 5;
  localparam int OUT_W   = 10;
  localparam int CLR_DLY = 5;  // address stages + memory read latency
  localparam int WR_DLY  = 6;  // plus the MAC stage

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t state_reg, state_next;

  logic [2:0] kc_reg, kr_reg;
  logic [3:0] oc_reg, orow_reg;

  logic run, kc_end, kr_end, oc_end, orow_end, last_count, first_tap, last_tap;

  assign run        = (state_reg == RUN);
  assign kc_end     = (kc_reg == 3'(K - 1));
  assign kr_end     = (kr_reg == 3'(K - 1));
  assign oc_end     = (oc_reg == 4'(OUT_W - 1));
  assign orow_end   = (orow_reg == 4'(OUT_W - 1));
  assign last_count = run && kc_end && kr_end && oc_end && orow_end;
  assign first_tap  = run && (kc_reg == 3'd0) && (kr_reg == 3'd0);
  assign last_tap   = run && kc_end && kr_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (conv2_start) state_next = RUN;
      RUN:     if (last_count)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters sit at zero outside RUN, so a new run always starts from window (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_reg   <= '0;
      kr_reg   <= '0;
      oc_reg   <= '0;
      orow_reg <= '0;
    end else if (!run) begin
      kc_reg   <= '0;
      kr_reg   <= '0;
      oc_reg   <= '0;
      orow_reg <= '0;
    end else begin
      kc_reg <= kc_end ? 3'd0 : kc_reg + 3'd1;
      if (kc_end)
        kr_reg <= kr_end ? 3'd0 : kr_reg + 3'd1;
      if (kc_end && kr_end)
        oc_reg <= oc_end ? 4'd0 : oc_reg + 4'd1;
      if (kc_end && kr_end && oc_end)
        orow_reg <= orow_end ? 4'd0 : orow_reg + 4'd1;
    end
  end

  // Three-stage address pipeline: sums, shift-add scaling, final add.
  logic [3:0] col_s1, row_s1, col_s2;
  logic [2:0] kr_s1, kc_s1, kc_s2;
  logic [7:0] row14_s2;
  logic [4:0] kr5_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1   <= '0;
      row_s1   <= '0;
      kr_s1    <= '0;
      kc_s1    <= '0;
      col_s2   <= '0;
      kc_s2    <= '0;
      row14_s2 <= '0;
      kr5_s2   <= '0;
      f3_raddr <= '0;
      w2_raddr <= '0;
    end else begin
      col_s1   <= oc_reg + {1'b0, kc_reg};
      row_s1   <= orow_reg + {1'b0, kr_reg};
      kr_s1    <= kr_reg;
      kc_s1    <= kc_reg;
      col_s2   <= col_s1;
      kc_s2    <= kc_s1;
      row14_s2 <= ({4'b0, row_s1} << 3) + ({4'b0, row_s1} << 2) + ({4'b0, row_s1} << 1);
      kr5_s2   <= ({2'b0, kr_s1} << 2) + {2'b0, kr_s1};
      f3_raddr <= row14_s2 + {4'b0, col_s2};
      w2_raddr <= kr5_s2 + {2'b0, kc_s2};
    end
  end

  // Control strobes are delay lines keyed off the counter cycle that produced them.
  logic [CLR_DLY-1:0] clr_sr;
  logic [WR_DLY-1:0]  wr_sr, done_sr;
  logic [6:0]         waddr_sr [WR_DLY-1];
  logic [6:0]         f4_waddr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_sr       <= '0;
      wr_sr        <= '0;
      done_sr      <= '0;
      waddr_sr[0]  <= '0;
      f4_waddr_reg <= '0;
    end else begin
      clr_sr      <= {clr_sr[CLR_DLY-2:0], first_tap};
      wr_sr       <= {wr_sr[WR_DLY-2:0], last_tap};
      done_sr     <= {done_sr[WR_DLY-2:0], state_reg == DONE};
      waddr_sr[0] <= ({3'b0, orow_reg} << 3) + ({3'b0, orow_reg} << 1) + {3'b0, oc_reg};
      if (wr_sr[WR_DLY-2])
        f4_waddr_reg <= waddr_sr[WR_DLY-2];
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < WR_DLY - 1; gi++) begin : g_waddr_dly
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) waddr_sr[gi] <= '0;
        else        waddr_sr[gi] <= waddr_sr[gi-1];
      end
    end
  endgenerate

  assign conv2_clr  = clr_sr[CLR_DLY-1];
  assign f4_wr_en   = wr_sr[WR_DLY-1];
  assign conv2_done = done_sr[WR_DLY-1];
  assign f4_waddr   = f4_waddr_reg;

endmodule
